mux2x1_behavioral_function_if_else: RTL and testbench
=====================================================

// Module: mux2x1_behavioral_function_if_else
// PURPOSE
//   Two-input, WIDTH-bit multiplexer with a selectable output register.
//   Selection is done by a behavioural function with if/else priority:
//   if (s) a1 else a0.
//   General-purpose datapath steering leaf cell. Its default configuration
//   is the registered 1-bit mux used by block-level benches.
// PARAMETERS
//   WIDTH    1  data width of a0, a1 and y (>=1)
//   REG_OUT  1  1: y registered on clk (latency 1); 0: y purely combinational
// PORTS
//   clk  in   1      single clock, rising-edge active
//   rst  in   1      reset, asynchronous, active-high
//   y    out  WIDTH  selected data (registered or combinational per REG_OUT)
//   s    in   1      select: 1 -> a1, 0 -> a0
//   a0   in   WIDTH  data input chosen when s is not 1
//   a1   in   WIDTH  data input chosen when s==1
//   Declaration order: clk, rst, y, s, a0, a1.
// BEHAVIOUR
//   - Selection function:
//       sel_f(s, a0, a1) = (s == 1'b1) ? a1 : a0
//     Coded as a function with an if/else body.
//   - X/Z handling: s of X or Z fails the if test, so a0 is selected.
//     The bench relies on this: no X propagation from s.
//   - Selection is bitwise-independent; no arithmetic, no width conversion.
//     a0, a1 and y are all exactly WIDTH bits.
//   - REG_OUT=1:
//     - y <= sel_f(s,a0,a1) on every rising clk edge. Latency is 1 cycle.
//       No enable and no handshake.
//     - rst=1 clears y to {WIDTH{1'b0}} immediately, without waiting for clk.
//     - y holds zero while rst is high. The first capture is the first
//       rising edge after rst falls.
//     - Reset asserted mid-operation discards the current value. Reset
//       wins over a simultaneous clk edge.
//   - REG_OUT=0:
//     - y = sel_f(s,a0,a1) continuously, with zero latency.
//     - clk and rst are unused. rst does not force y.
//   - Simultaneous changes on s and data within a cycle: only the values
//     present at the sampling edge matter (REG_OUT=1). No glitch
//     requirement on the combinational path.
//   - No internal state other than the optional output register.
// STRUCTURE
//   - Shared package mux_pkg: function automatic mux2_sel, parameterised by
//     WIDTH through a typed wrapper or macro. Also the reset-value constant
//     MUX_RST_VAL = '0.
//   - Generate block on REG_OUT chooses the registered or direct path.
//   - One natural sub-module: mux_out_reg (WIDTH-bit async-reset,
//     active-high D flip-flop). It is instantiated only when REG_OUT=1.
// TESTING
//   1. Truth table, WIDTH=1, REG_OUT=1. Drive all 8 (s,a0,a1) combos, one
//      per cycle. One cycle later:
//        y = 0,0,1,0,0,1,1,1 for (s,a0,a1)=000,100,010,110,001,101,011,111.
//   2. Async reset: set s=1, a1=1 and let y=1. Pulse rst between clock
//      edges -> y=0 at once, with no clk edge. After release, y=1 on the
//      next edge.
//   3. X select: s=1'bx, a0=1, a1=0 -> y=1 after one edge (a0 chosen).
//      Never X.
//   4. WIDTH=8, REG_OUT=1: a0=8'hA5, a1=8'h3C. Toggle s=0,1,0 -> y=A5,3C,A5,
//      each one cycle late.
//   5. REG_OUT=0, WIDTH=1: repeat the scenario 1 table with 1-time-unit
//      steps. y matches within the same step, and rst has no effect.
//   6. Reset held for 5 cycles with inputs toggling -> y stays 0
//      throughout.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the two-input multiplexer leaf cells.
//
// Contents:
//   MUX_RST_VAL - single-bit value that the output register loads on
//                 reset. Replicate it to the data width where it is used.
//   mux2_sel    - one-bit behavioural select with if/else priority.
//                 Wider muxes apply it to every bit through a typed
//                 wrapper in the instantiating module. Selection is
//                 bitwise-independent, so this gives the same result as
//                 a word-wide if/else.
package mux_pkg;

  localparam logic MUX_RST_VAL = '0;

  // An s of X or Z fails the if test and falls through to a0. Downstream
  // logic depends on this, so a ternary is deliberately not used here:
  // a ternary would merge the two inputs when s is unknown.
  function automatic logic mux2_sel(input logic s, input logic a0, input logic a1);
    logic r;
    if (s) begin
      r = a1;
    end else begin
      r = a0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// WIDTH-bit D flip-flop with an asynchronous, active-high clear.
//
// Ports:
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous clear, active-high; also wins over a
//                    simultaneous clk edge
//   d    in   WIDTH  next value
//   q    out  WIDTH  registered value; MUX_RST_VAL replicated while rst is high
module mux_out_reg
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {WIDTH{MUX_RST_VAL}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux2x1_behavioral_function_if_else.sv
// Two-input, WIDTH-bit multiplexer with an optional output register.
// This is a general-purpose datapath steering leaf cell.
//
// Parameters:
//   WIDTH    data width of a0, a1 and y (>=1)
//   REG_OUT  1: y is registered on clk (latency 1, async clear on rst)
//            0: y is purely combinational; clk and rst are ignored
//
// Ports:
//   clk  in   1      rising-edge clock (used only when REG_OUT=1)
//   rst  in   1      asynchronous active-high reset (used only when REG_OUT=1)
//   y    out  WIDTH  selected data
//   s    in   1      select: 1 -> a1, anything else (0/X/Z) -> a0
//   a0   in   WIDTH  data chosen when s is not 1
//   a1   in   WIDTH  data chosen when s == 1
module mux2x1_behavioral_function_if_else
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y,
  input  logic             s,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1
);

  // This wrapper applies the one-bit package select to each bit at this
  // instance's width. Each bit sees the same s, so the result is the
  // word-wide selection "if (s) a1 else a0".
  function automatic logic [WIDTH-1:0] sel_f(
    input logic             sel,
    input logic [WIDTH-1:0] d0,
    input logic [WIDTH-1:0] d1
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = mux2_sel(sel, d0[i], d1[i]);
    end
    return r;
  endfunction

  logic [WIDTH-1:0] sel_d;

  always_comb begin
    sel_d = sel_f(s, a0, a1);
  end

  generate
    if (REG_OUT) begin : g_reg
      mux_out_reg #(
        .WIDTH(WIDTH)
      ) u_out_reg (
        .clk(clk),
        .rst(rst),
        .d  (sel_d),
        .q  (y)
      );
    end else begin : g_comb
      // The combinational variant keeps clk and rst in the port list so
      // that both variants are drop-in replacements for each other. The
      // two inputs are consumed here only so that they count as used.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign y = sel_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux2x1_behavioral_function_if_else.sv
// Scoreboard bench for mux2x1_behavioral_function_if_else.
//
// The bench drives three instances:
//   dut_w1   - WIDTH=1, registered
//   dut_w8   - WIDTH=8, registered
//   dut_comb - WIDTH=1, combinational; it shares its inputs with dut_w1
//
// Stimulus is driven 1 unit after a rising edge. Each driven cycle pushes
// the expected registered outputs into a queue, tagged with the cycle in
// which they become visible. A monitor on the falling edge pops each due
// entry and compares it. The monitor also checks the combinational
// instance against the current inputs. While rst is high, the registered
// outputs are expected to be zero, whatever the queue holds.
module tb_mux2x1_behavioral_function_if_else;

  logic       clk = 1'b0;
  logic       rst;
  logic       s1, a0_1, a1_1;
  logic       y_reg1, y_comb;
  logic       s8;
  logic [7:0] a0_8, a1_8, y_reg8;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int         due;
    logic       exp1;
    logic [7:0] exp8;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Expected y for (s,a0,a1) = 000,100,010,110,001,101,011,111.
  logic tt_y [8];

  logic       rs, ra0, ra1, rs8;
  logic [7:0] r8a, r8b;

  always #10 clk = ~clk;

  always @(posedge clk) cycle++;

  mux2x1_behavioral_function_if_else #(.WIDTH(1), .REG_OUT(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .y(y_reg1), .s(s1), .a0(a0_1), .a1(a1_1)
  );

  mux2x1_behavioral_function_if_else #(.WIDTH(8), .REG_OUT(1'b1)) dut_w8 (
    .clk(clk), .rst(rst), .y(y_reg8), .s(s8), .a0(a0_8), .a1(a1_8)
  );

  mux2x1_behavioral_function_if_else #(.WIDTH(1), .REG_OUT(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .y(y_comb), .s(s1), .a0(a0_1), .a1(a1_1)
  );

  // Reference rule: only a select of exactly 1 picks a1.
  function automatic logic ref_sel1(input logic s, input logic a0, input logic a1);
    return (s === 1'b1) ? a1 : a0;
  endfunction

  function automatic logic [7:0] ref_sel8(input logic s, input logic [7:0] a0, input logic [7:0] a1);
    return (s === 1'b1) ? a1 : a0;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushExpected(input logic e1, input logic [7:0] e8);
    sb_q.push_back('{due: cycle + 1, exp1: rst ? 1'b0 : e1, exp8: rst ? 8'h00 : e8});
  endtask

  task automatic applyStimulus(input logic sv, input logic a0v, input logic a1v,
                               input logic s8v, input logic [7:0] a08, input logic [7:0] a18,
                               input logic e1, input logic [7:0] e8);
    @(posedge clk);
    #1;
    s1   = sv;
    a0_1 = a0v;
    a1_1 = a1v;
    s8   = s8v;
    a0_8 = a08;
    a1_8 = a18;
    pushExpected(e1, e8);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
      mon_e = sb_q.pop_front();
      checkOutput("y_w1", {7'b0, y_reg1}, rst ? 8'h00 : {7'b0, mon_e.exp1});
      checkOutput("y_w8", y_reg8, rst ? 8'h00 : mon_e.exp8);
    end
    checkOutput("y_comb", {7'b0, y_comb}, {7'b0, ref_sel1(s1, a0_1, a1_1)});
  end

  initial begin
    logic [2:0] b;

    tt_y = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst  = 1'b1;
    s1   = 1'b0; a0_1 = 1'b0; a1_1 = 1'b0;
    s8   = 1'b0; a0_8 = 8'h00; a1_8 = 8'h00;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_w1", {7'b0, y_reg1}, 8'h00);
    checkOutput("reset_w8", y_reg8, 8'h00);
    rst = 1'b0;

    // Truth table on the 1-bit registered mux, with random 8-bit traffic.
    for (int i = 0; i < 8; i++) begin
      b   = 3'(i);
      rs8 = 1'($urandom_range(0, 1));
      r8a = 8'($urandom);
      r8b = 8'($urandom);
      applyStimulus(b[0], b[1], b[2], rs8, r8a, r8b, tt_y[i], ref_sel8(rs8, r8a, r8b));
    end

    // 8-bit constants with select toggling 0,1,0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 8'hA5);

    // Unknown select falls through to a0.
    applyStimulus(1'bx, 1'b1, 1'b0, 1'bx, 8'h5A, 8'hC3, ref_sel1(1'bx, 1'b1, 1'b0), 8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22);

    // Asynchronous reset pulse between edges, with y at 1 beforehand.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h22);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_w1", {7'b0, y_reg1}, 8'h00);
    checkOutput("async_rst_w8", y_reg8, 8'h00);
    checkOutput("async_rst_comb", {7'b0, y_comb}, 8'h01);
    #1;
    rst = 1'b0;
    pushExpected(1'b1, 8'h22);

    // Combinational truth table in 1-unit steps, all within one cycle.
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      b    = 3'(i);
      s1   = b[0];
      a0_1 = b[1];
      a1_1 = b[2];
      #1;
      checkOutput("comb_tt", {7'b0, y_comb}, {7'b0, tt_y[i]});
    end
    pushExpected(ref_sel1(s1, a0_1, a1_1), ref_sel8(s8, a0_8, a1_8));

    // Reset held for 5 cycles while the inputs keep toggling.
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_hold_entry", {7'b0, y_reg1}, 8'h00);
    for (int k = 0; k < 5; k++) begin
      rs  = 1'($urandom_range(0, 1));
      ra0 = 1'($urandom_range(0, 1));
      ra1 = 1'($urandom_range(0, 1));
      rs8 = 1'($urandom_range(0, 1));
      r8a = 8'($urandom);
      r8b = 8'($urandom);
      applyStimulus(rs, ra0, ra1, rs8, r8a, r8b, ref_sel1(rs, ra0, ra1), ref_sel8(rs8, r8a, r8b));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomised traffic on both registered widths.
    for (int k = 0; k < 40; k++) begin
      rs  = 1'($urandom_range(0, 1));
      ra0 = 1'($urandom_range(0, 1));
      ra1 = 1'($urandom_range(0, 1));
      rs8 = 1'($urandom_range(0, 1));
      r8a = 8'($urandom);
      r8b = 8'($urandom);
      applyStimulus(rs, ra0, ra1, rs8, r8a, r8b, ref_sel1(rs, ra0, ra1), ref_sel8(rs8, r8a, r8b));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
